fir_mc_core: RTL

- Parametrised, multi-channel successor to the single-channel FIR datapath. One shared signed MAC computes a FIR for CH_NUM time-interleaved channels with a shared coefficient set held in the external tap BRAM.
- Per-channel sample history is held internally in a register array; there is no external shifter IP.
- AXI4-Stream sample input and output. Output is scaled (arithmetic right shift), then saturated to a configurable width.
- Sits between the AXI-Lite config register block (ap_start/ap_done, lengths, shift) and the stream fabric.

---
 rtl/fir_mc_core.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/fir_mc_core.sv
`default_nettype none
// ============================================================================
// fir_mc_core : multi-channel FIR, one shared signed MAC, AXI4-Stream in/out
// Revision    : 1.0
// ============================================================================
module fir_mc_core #(
  parameter int DATA_W = 32,
  parameter int TAP_AW = 4,
  parameter int LEN_W  = 10,
  parameter int CH_NUM = 2,
  parameter int OUT_W  = 32,
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_ap_start,
  output logic              out_ap_done,
  output logic              out_ap_idle,
  input  logic [TAP_AW:0]   in_tap_num,
  input  logic [LEN_W-1:0]  in_data_num,
  input  logic [5:0]        in_shift,
  output logic [TAP_AW-1:0] out_A_tap,
  output logic              out_EN_tap,
  input  logic [DATA_W-1:0] in_Do_tap,
  input  logic              in_ss_tvalid,
  output logic              out_ss_tready,
  input  logic [DATA_W-1:0] in_ss_tdata,
  output logic              out_sm_tvalid,
  input  logic              in_sm_tready,
  output logic [OUT_W-1:0]  out_sm_tdata,
  output logic [CH_W-1:0]   out_sm_tuser,
  output logic              out_sm_tlast
);

  localparam int NTAP   = 1 << TAP_AW;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + TAP_AW;
  localparam int CNT_W  = TAP_AW + 2;
  localparam int BEAT_W = LEN_W + 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_WAIT_IN = 3'd2,
    S_MAC     = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [TAP_AW:0]           taps_q, taps_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [5:0]                shift_q, shift_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      rd_vld_q, rd_vld_d;
  logic [TAP_AW-1:0]         idx_q, idx_d;
  logic                      prod_vld_q, prod_vld_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      done_clr_q, done_clr_d;
  logic signed [DATA_W-1:0]  hist_q [CH_NUM][NTAP];
  logic signed [DATA_W-1:0]  hist_d [CH_NUM][NTAP];

  logic [TAP_AW:0]           w_taps_clamped;
  logic [BEAT_W-1:0]         w_total;
  logic                      w_last;
  logic                      w_issue;
  logic                      w_sm_hs;
  logic signed [DATA_W-1:0]  w_hist_sel;
  logic signed [ACC_W-1:0]   w_shifted;
  logic [ACC_W-OUT_W:0]      w_upper;
  logic                      w_ovf;
  logic [OUT_W-1:0]          w_sat;

  // Zero taps degenerate to a single tap; oversize requests use the full BRAM.
  always_comb begin
    w_taps_clamped = in_tap_num;
    if (in_tap_num == '0) begin
      w_taps_clamped = (TAP_AW+1)'(1);
    end else if (in_tap_num > (TAP_AW+1)'(NTAP)) begin
      w_taps_clamped = (TAP_AW+1)'(NTAP);
    end
  end

  always_comb begin
    w_total = BEAT_W'(len_q) * BEAT_W'(CH_NUM);
    w_last  = (beat_q + BEAT_W'(1)) == w_total;
    w_issue = (state_q == S_MAC) && (cnt_q < CNT_W'(taps_q));
    w_sm_hs = (state_q == S_OUT) && in_sm_tready;
  end

  always_comb begin
    state_d    = state_q;
    taps_d     = taps_q;
    len_d      = len_q;
    shift_d    = shift_q;
    ch_d       = ch_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    done_clr_d = 1'b0;
    hist_d     = hist_q;
    case (state_q)
      S_IDLE: begin
        if (in_ap_start) begin
          taps_d  = w_taps_clamped;
          len_d   = in_data_num;
          shift_d = in_shift;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        for (int c = 0; c < CH_NUM; c++) begin
          for (int t = 0; t < NTAP; t++) begin
            hist_d[c][t] = '0;
          end
        end
        ch_d   = '0;
        beat_d = '0;
        if (len_q == '0) begin
          done_clr_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (in_ss_tvalid) begin
          for (int c = 0; c < CH_NUM; c++) begin
            if (ch_q == CH_W'(c)) begin
              for (int t = NTAP - 1; t > 0; t--) begin
                hist_d[c][t] = hist_q[c][t-1];
              end
              hist_d[c][0] = in_ss_tdata;
            end
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MAC;
        end
      end
      // Runs N issue cycles plus two drain cycles for BRAM and product latency.
      S_MAC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (prod_vld_q) begin
          acc_d = acc_q + {{TAP_AW{prod_q[PROD_W-1]}}, prod_q};
        end
        if (cnt_q == CNT_W'(taps_q) + CNT_W'(1)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (in_sm_tready) begin
          beat_d  = beat_q + BEAT_W'(1);
          ch_d    = (ch_q == CH_W'(CH_NUM - 1)) ? '0 : ch_q + CH_W'(1);
          state_d = w_last ? S_IDLE : S_WAIT_IN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tap data lands one cycle after its address; idx_q keeps it paired with history.
  always_comb begin
    w_hist_sel = hist_q[ch_q][idx_q];
    rd_vld_d   = w_issue;
    idx_d      = w_issue ? cnt_q[TAP_AW-1:0] : idx_q;
    prod_vld_d = rd_vld_q;
    prod_d     = prod_q;
    if (rd_vld_q) begin
      prod_d = PROD_W'($signed(in_Do_tap)) * PROD_W'(w_hist_sel);
    end
  end

  always_comb begin
    w_shifted = acc_q >>> shift_q;
    w_upper   = w_shifted[ACC_W-1:OUT_W-1];
    w_ovf     = !((&w_upper) || !(|w_upper));
    w_sat     = w_shifted[OUT_W-1:0];
    if (w_ovf) begin
      w_sat = w_shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_comb begin
    out_ap_idle   = (state_q == S_IDLE);
    out_ap_done   = (w_sm_hs && w_last) || done_clr_q;
    out_ss_tready = (state_q == S_WAIT_IN);
    out_EN_tap    = w_issue;
    out_A_tap     = w_issue ? cnt_q[TAP_AW-1:0] : '0;
    out_sm_tvalid = (state_q == S_OUT);
    out_sm_tdata  = out_sm_tvalid ? w_sat : '0;
    out_sm_tuser  = out_sm_tvalid ? ch_q : '0;
    out_sm_tlast  = out_sm_tvalid && w_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      taps_q     <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      ch_q       <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      rd_vld_q   <= 1'b0;
      idx_q      <= '0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      done_clr_q <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        for (int t = 0; t < NTAP; t++) begin
          hist_q[c][t] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      taps_q     <= taps_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      ch_q       <= ch_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      rd_vld_q   <= rd_vld_d;
      idx_q      <= idx_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      done_clr_q <= done_clr_d;
      hist_q     <= hist_d;
    end
  end

endmodule
`default_nettype wire
